// File: rtl/mem_burst_scheduler_if.sv
// mem_burst_scheduler_if: signal bundle between two requesters, the burst scheduler and the downstream memory port
//   req_*/rw_*/addr_*/len_* : per-port request held until ack_*
//   ack_*                   : one-cycle completion pulse per port
//   m_cmd_*                 : downstream burst command with valid/ready handshake
//   m_beat                  : one pulse per transferred word of the accepted burst
//   grant/word_idx          : owning port of the current burst and its next word index
interface mem_burst_scheduler_if #(
  parameter int ADDR_W = 48,
  parameter int LEN_W  = 32
);
  logic              req_0, req_1, rw_0, rw_1, ack_0, ack_1;
  logic [ADDR_W-1:0] addr_0, addr_1;
  logic [LEN_W-1:0]  len_0, len_1;
  logic              m_cmd_valid, m_cmd_ready, m_cmd_rw, m_beat, grant;
  logic [ADDR_W-1:0] m_cmd_addr;
  logic [LEN_W-1:0]  m_cmd_len, word_idx;
  modport master (
    output req_0, req_1, rw_0, rw_1, addr_0, addr_1, len_0, len_1, m_cmd_ready, m_beat,
    input  ack_0, ack_1, m_cmd_valid, m_cmd_rw, m_cmd_addr, m_cmd_len, grant, word_idx
  );
  modport slave (
    input  req_0, req_1, rw_0, rw_1, addr_0, addr_1, len_0, len_1, m_cmd_ready, m_beat,
    output ack_0, ack_1, m_cmd_valid, m_cmd_rw, m_cmd_addr, m_cmd_len, grant, word_idx
  );
endinterface

// File: rtl/mem_burst_scheduler.sv
// mem_burst_scheduler: two-port round-robin scheduler splitting word requests into bursts of at most MAX_BURST words
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of mem_burst_scheduler_if (requests/acks, downstream command, beats, grant, word_idx)
module mem_burst_scheduler #(
  parameter int ADDR_W    = 48,
  parameter int LEN_W     = 32,
  parameter int MAX_BURST = 256
) (
  input logic                  clk,
  input logic                  rst_n,
  mem_burst_scheduler_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CMD, DATA, ACK} state_t;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BURST);
  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);
  state_t                  state_q, state_d;
  logic                    grant_q, grant_d, last_q, last_d, win;
  logic [1:0]              vld_q, vld_d, rw_q, rw_d, blk_q, blk_d;
  logic [1:0][LEN_W-1:0]   rem_q, rem_d, idx_q, idx_d;
  logic [1:0][ADDR_W-1:0]  adr_q, adr_d;
  logic [LEN_W-1:0]        cnt_q, cnt_d, cmd_len;
  logic [1:0]              req_in, rw_in;
  logic [1:0][LEN_W-1:0]   len_in;
  logic [1:0][ADDR_W-1:0]  addr_in;
  assign req_in  = {bus.req_1, bus.req_0};
  assign rw_in   = {bus.rw_1, bus.rw_0};
  assign len_in  = {bus.len_1, bus.len_0};
  assign addr_in = {bus.addr_1, bus.addr_0};
  assign cmd_len = rem_q[grant_q] > MAX_LEN ? MAX_LEN : rem_q[grant_q];
  assign bus.m_cmd_valid = state_q == CMD;
  assign bus.m_cmd_rw    = rw_q[grant_q];
  assign bus.m_cmd_addr  = adr_q[grant_q];
  assign bus.m_cmd_len   = cmd_len;
  assign bus.ack_0       = state_q == ACK && !grant_q;
  assign bus.ack_1       = state_q == ACK && grant_q;
  assign bus.grant       = grant_q;
  assign bus.word_idx    = idx_q[grant_q];
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    vld_d   = vld_q;
    rw_d    = rw_q;
    rem_d   = rem_q;
    adr_d   = adr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    blk_d   = '0;
    win     = 1'b0;
    case (state_q)
      IDLE: begin
        // a fresh request is latched and may win arbitration in the same cycle;
        // blk_q keeps a just-acked port from re-latching its still-high req
        for (int p = 0; p < 2; p++)
          if (req_in[p] && !vld_q[p] && !blk_q[p]) begin
            vld_d[p] = 1'b1;
            rw_d[p]  = rw_in[p];
            rem_d[p] = len_in[p];
            adr_d[p] = addr_in[p];
            idx_d[p] = '0;
          end
        win = &vld_d ? ~last_q : vld_d[1];
        if (|vld_d) begin
          grant_d = win;
          last_d  = win;
          state_d = rem_d[win] == '0 ? ACK : CMD;
        end
      end
      CMD: if (bus.m_cmd_ready) begin
        cnt_d   = cmd_len;
        state_d = DATA;
      end
      DATA: if (bus.m_beat) begin
        idx_d[grant_q] = idx_q[grant_q] + ONE;
        rem_d[grant_q] = rem_q[grant_q] - ONE;
        adr_d[grant_q] = adr_q[grant_q] + ADDR_W'(8);
        cnt_d          = cnt_q - ONE;
        if (cnt_q == ONE) state_d = rem_q[grant_q] == ONE ? ACK : IDLE;
      end
      default: begin
        vld_d[grant_q] = 1'b0;
        rw_d[grant_q]  = 1'b0;
        rem_d[grant_q] = '0;
        adr_d[grant_q] = '0;
        idx_d[grant_q] = '0;
        blk_d[grant_q] = 1'b1;
        state_d        = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      vld_q   <= '0;
      rw_q    <= '0;
      blk_q   <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
      adr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      vld_q   <= vld_d;
      rw_q    <= rw_d;
      blk_q   <= blk_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      adr_q   <= adr_d;
      cnt_q   <= cnt_d;
    end
endmodule

// File: tb/tb_mem_burst_scheduler.sv
// tb_mem_burst_scheduler: directed and randomized scoreboard bench for mem_burst_scheduler
module tb_mem_burst_scheduler;
  typedef struct packed {logic rw; logic [47:0] addr; logic [31:0] len;} cmd_t;
  logic        clk = 1'b0, rst_n = 1'b1;
  int          n_cmp = 0, n_err = 0, rdy_mode = 0;
  cmd_t        cmdq[2][$];
  logic [31:0] ackq[2][$];
  int          order_q[$], ack_order[$];
  logic [31:0] exp_idx[2];
  logic        started[2];
  mem_burst_scheduler_if bus();
  mem_burst_scheduler dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask
  task automatic fail(string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event occurred, required none", nm);
  endtask
  task automatic drive(int p, logic r, logic w, logic [47:0] a, logic [31:0] l);
    if (p == 0) begin
      bus.req_0 = r; bus.rw_0 = w; bus.addr_0 = a; bus.len_0 = l;
    end else begin
      bus.req_1 = r; bus.rw_1 = w; bus.addr_1 = a; bus.len_1 = l;
    end
  endtask
  // reference: a request becomes consecutive chunks of at most 256 words, addresses wrapping at 2^48
  task automatic push_req(int p, logic w, logic [47:0] a, logic [31:0] l, logic with_ack);
    logic [31:0] r, c;
    logic [47:0] x;
    r = l;
    x = a;
    while (r != 0) begin
      c = r > 32'd256 ? 32'd256 : r;
      cmdq[p].push_back(cmd_t'({w, x, c}));
      x = x + 48'(c) * 48'd8;
      r = r - c;
    end
    if (with_ack) ackq[p].push_back(l);
  endtask
  task automatic issue(int p, logic w, logic [47:0] a, logic [31:0] l);
    @(posedge clk); #1;
    started[p] = 1'b0;
    drive(p, 1'b1, w, a, l);
    push_req(p, w, a, l, 1'b1);
  endtask
  function automatic logic [47:0] rnd_addr();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return $urandom_range(0, 3) == 0 ? (48'hFFFF_FFFF_F000 | (t[47:0] & 48'hFF8)) : t[47:0] & ~48'h7;
  endfunction
  function automatic logic [31:0] rnd_len();
    int k;
    k = int'($urandom_range(0, 9));
    return k == 0 ? 32'd0 : k < 3 ? 32'($urandom_range(250, 600)) : 32'($urandom_range(1, 40));
  endfunction
  task automatic wait_ack(int p, logic scr);
    logic got;
    got = 1'b0;
    for (int k = 0; k < 6000 && !got; k++) begin
      @(posedge clk); #1;
      if (scr && started[p]) drive(p, 1'b1, 1'($urandom_range(0, 1)), rnd_addr(), rnd_len());
      @(negedge clk);
      got = p == 0 ? bus.ack_0 : bus.ack_1;
    end
    if (!got) chk("ack_timeout", 0, 1);
    @(posedge clk); #1;
    drive(p, 1'b0, 1'b0, '0, '0);
  endtask
  task automatic reset_chk();
    chk("rst_valid", bus.m_cmd_valid, 0);
    chk("rst_ack0", bus.ack_0, 0);
    chk("rst_ack1", bus.ack_1, 0);
    chk("rst_rw", bus.m_cmd_rw, 0);
    chk("rst_addr", bus.m_cmd_addr, 0);
    chk("rst_len", bus.m_cmd_len, 0);
    chk("rst_grant", bus.grant, 0);
    chk("rst_word_idx", bus.word_idx, 0);
  endtask
  task automatic requester(int p, int n);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 4)) @(posedge clk);
      issue(p, 1'($urandom_range(0, 1)), rnd_addr(), rnd_len());
      wait_ack(p, 1'b1);
    end
  endtask
  // downstream memory model: random ready, beats only while a burst is owed, stray beats otherwise
  initial begin
    logic        pv;
    logic [31:0] pl;
    int          bl;
    pv = 1'b0; pl = '0; bl = 0;
    bus.m_cmd_ready = 1'b0;
    bus.m_beat = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        pv = 1'b0; bl = 0; bus.m_beat = 1'b0;
      end else begin
        if (bus.m_beat && bl > 0) bl--;
        else if (pv && bus.m_cmd_ready) bl = int'(pl);
        bus.m_cmd_ready = rdy_mode == 1 ? 1'b1 : rdy_mode == 2 ? 1'b0 : ($urandom_range(0, 2) != 0);
        bus.m_beat = bl > 0 ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
        pv = bus.m_cmd_valid;
        pl = bus.m_cmd_len;
      end
    end
  end
  // monitor: pops expected commands/acks whenever the DUT presents them
  initial begin
    int          bl, cyc;
    int          lbc[2];
    logic        bg, g, pvld, prdy, prw;
    logic [47:0] pa;
    logic [31:0] pln, l;
    logic        pack[2];
    cmd_t        e;
    bl = 0; cyc = 0; bg = 0; pvld = 0; prdy = 0; prw = 0; pa = '0; pln = '0;
    lbc[0] = 0; lbc[1] = 0; pack[0] = 0; pack[1] = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        bl = 0; pvld = 0; pack[0] = 0; pack[1] = 0;
      end else begin
        if (pvld && !prdy) begin
          chk("hold_valid", bus.m_cmd_valid, 1);
          chk("hold_rw", bus.m_cmd_rw, prw);
          chk("hold_addr", bus.m_cmd_addr, pa);
          chk("hold_len", bus.m_cmd_len, pln);
        end
        if (bus.m_cmd_valid) chk("cmd_len_nonzero", bus.m_cmd_len == 0, 0);
        if (bus.m_beat && bl > 0) begin
          chk("beat_grant", bus.grant, bg);
          chk("word_idx", bus.word_idx, exp_idx[bg]);
          exp_idx[bg]++;
          bl--;
          if (bl == 0) lbc[bg] = cyc;
        end
        if (bus.m_cmd_valid && bus.m_cmd_ready) begin
          g = bus.grant;
          if (cmdq[g].size() == 0) fail("unexpected_cmd");
          else begin
            e = cmdq[g].pop_front();
            chk("cmd_rw", bus.m_cmd_rw, e.rw);
            chk("cmd_addr", bus.m_cmd_addr, e.addr);
            chk("cmd_len", bus.m_cmd_len, e.len);
          end
          if (order_q.size() != 0) chk("grant_order", g, order_q.pop_front());
          started[g] = 1'b1;
          bl = int'(bus.m_cmd_len);
          bg = g;
        end
        for (int p = 0; p < 2; p++)
          if (p == 0 ? bus.ack_0 : bus.ack_1) begin
            chk("ack_exclusive", bus.ack_0 & bus.ack_1, 0);
            chk("ack_pulse", pack[p], 0);
            chk("ack_grant", bus.grant, p);
            if (ackq[p].size() == 0) fail("unexpected_ack");
            else begin
              l = ackq[p].pop_front();
              chk("ack_words", exp_idx[p], l);
              chk("ack_word_idx", bus.word_idx, l);
              chk("ack_pending_cmds", cmdq[p].size(), 0);
              if (l != 0) chk("ack_latency", cyc - lbc[p], 1);
            end
            exp_idx[p] = '0;
            ack_order.push_back(p);
          end
        pvld = bus.m_cmd_valid; prdy = bus.m_cmd_ready; prw = bus.m_cmd_rw;
        pa = bus.m_cmd_addr; pln = bus.m_cmd_len;
        pack[0] = bus.ack_0; pack[1] = bus.ack_1;
      end
    end
  end
  initial begin
    #900000;
    $display("FAIL watchdog: got no finish by 900000, required finish");
    $fatal(1, "watchdog expired");
  end
  initial begin
    logic got;
    exp_idx[0] = '0; exp_idx[1] = '0; started[0] = 0; started[1] = 0;
    drive(0, 0, 0, '0, '0);
    drive(1, 0, 0, '0, '0);
    #3 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_chk();
    @(negedge clk) rst_n = 1'b1;
    rdy_mode = 1;
    issue(0, 1'b0, 48'h1000, 32'd4);
    wait_ack(0, 1'b0);
    rdy_mode = 0;
    issue(1, 1'b0, 48'h40_0000, 32'd600);
    wait_ack(1, 1'b0);
    @(posedge clk); #1;
    ack_order.delete();
    order_q.push_back(0); order_q.push_back(1); order_q.push_back(0); order_q.push_back(1);
    drive(0, 1'b1, 1'b0, 48'h1_0000, 32'd300);
    drive(1, 1'b1, 1'b1, 48'h2_0000, 32'd300);
    push_req(0, 1'b0, 48'h1_0000, 32'd300, 1'b1);
    push_req(1, 1'b1, 48'h2_0000, 32'd300, 1'b1);
    wait_ack(0, 1'b0);
    wait_ack(1, 1'b0);
    chk("order_consumed", order_q.size(), 0);
    chk("ack_order_count", ack_order.size(), 2);
    if (ack_order.size() == 2) begin
      chk("ack_order_first", ack_order[0], 0);
      chk("ack_order_second", ack_order[1], 1);
    end
    rdy_mode = 2;
    issue(0, 1'b1, 48'h2000, 32'd5);
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      got = bus.m_cmd_valid;
    end
    chk("bp_valid_seen", got, 1);
    for (int k = 0; k < 10; k++) begin
      chk("bp_valid", bus.m_cmd_valid, 1);
      chk("bp_ready_low", bus.m_cmd_ready, 0);
      chk("bp_addr", bus.m_cmd_addr, 48'h2000);
      chk("bp_len", bus.m_cmd_len, 5);
      chk("bp_rw", bus.m_cmd_rw, 1);
      @(negedge clk);
    end
    rdy_mode = 0;
    wait_ack(0, 1'b0);
    issue(0, 1'b0, 48'h3000, 32'd0);
    wait_ack(0, 1'b0);
    rdy_mode = 1;
    issue(0, 1'b0, 48'h5000, 32'd8);
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      got = bus.word_idx == 2;
    end
    chk("mid_burst_reached", got, 1);
    #2 rst_n = 1'b0;
    #1 reset_chk();
    exp_idx[0] = '0;
    cmdq[0].delete();
    push_req(0, 1'b0, 48'h5000, 32'd8, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_ack(0, 1'b0);
    rdy_mode = 0;
    fork
      requester(0, 12);
      requester(1, 12);
    join
    repeat (5) @(negedge clk);
    chk("left_cmds0", cmdq[0].size(), 0);
    chk("left_cmds1", cmdq[1].size(), 0);
    chk("left_acks0", ackq[0].size(), 0);
    chk("left_acks1", ackq[1].size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_burst_scheduler.md
MEM_BURST_SCHEDULER -- requirements
Module: mem_burst_scheduler

Interface
REQ-001 SHALL have parameter ADDR_W, default 48, byte-address width.
REQ-002 SHALL have parameter LEN_W, default 32, request length in 64-bit words.
REQ-003 SHALL have parameter MAX_BURST, default 256, maximum words per downstream command; power of two, >=2.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports req_0/req_1, input, 1, requester holds high until its ack.
REQ-007 SHALL have ports rw_0/rw_1, input, 1, 1=write, 0=read; sampled with req.
REQ-008 SHALL have ports addr_0/addr_1, input, ADDR_W, start byte address, 8-byte aligned.
REQ-009 SHALL have ports len_0/len_1, input, LEN_W, total words.
REQ-010 SHALL have ports ack_0/ack_1, output, 1, one-cycle pulse when the whole request completes.
REQ-011 SHALL have port m_cmd_valid, output, 1, downstream command valid.
REQ-012 SHALL have port m_cmd_ready, input, 1, downstream accepts command when valid&ready.
REQ-013 SHALL have ports m_cmd_rw (1), m_cmd_addr (ADDR_W), m_cmd_len (LEN_W), outputs, burst descriptor.
REQ-014 SHALL have port m_beat, input, 1, one pulse per word transferred for the accepted burst.
REQ-015 SHALL have port grant, output, 1, owning port of the current burst (data mux select).
REQ-016 SHALL have port word_idx, output, LEN_W, index of the next word within the owner's request.

Function
REQ-017 SHALL implement states IDLE, CMD, DATA, ACK.
REQ-018 IDLE: on first sight of a port's req with no saved context, SHALL latch rw/addr/len into that port's context (rem, next_addr, idx=0); later req-held changes SHALL be ignored.
REQ-019 IDLE arbitration SHALL be round-robin: eligible port != last_grant wins if both eligible; else the single eligible port; last_grant updates on each grant.
REQ-020 A port with len=0 SHALL go IDLE -> ACK directly, issuing no command.
REQ-021 CMD: m_cmd_valid=1, m_cmd_len=min(rem, MAX_BURST), m_cmd_addr=next_addr, m_cmd_rw=latched rw; all held stable until valid&ready; then -> DATA.
REQ-022 DATA: each m_beat SHALL increment word_idx, decrement rem and add 8 to next_addr; after the burst's last beat: rem==0 -> ACK, else -> IDLE for re-arbitration.
REQ-023 Re-arbitration between bursts SHALL let the other port win if eligible, interleaving bursts; a port's context SHALL persist across lost arbitration.
REQ-024 ACK: SHALL pulse ack_<grant> exactly one cycle, clear that context, -> IDLE; the acked port SHALL be ineligible the following cycle so a still-high req is not re-latched.
REQ-025 m_beat outside DATA SHALL be ignored; m_cmd_ready outside CMD SHALL be ignored.
REQ-026 m_cmd_valid SHALL never be high with m_cmd_len=0.
REQ-027 Address arithmetic SHALL wrap modulo 2^ADDR_W; lengths are unsigned LEN_W.
REQ-028 word_idx SHALL show the granted port's idx; grant SHALL change only in IDLE.
REQ-029 ack_0 and ack_1 SHALL never be high in the same cycle.

Reset
REQ-030 On rst_n low, asynchronously: state=IDLE, ack_0=ack_1=0, m_cmd_valid=0, m_cmd_rw=0, m_cmd_addr=0, m_cmd_len=0, grant=0, word_idx=0, last_grant=1, both contexts cleared.
REQ-031 Reset mid-burst SHALL abandon all transfers with no ack; after release, requests still high SHALL be re-latched from scratch.

Verification
REQ-032 Single read: req_0, addr_0=0x1000, len_0=4, ready held high -> one command (rw=0, addr 0x1000, len 4), 4 beats, ack_0 one cycle after 4th beat.
REQ-033 Split: len_1=600, MAX_BURST=256, only port 1 -> commands len 256@A, 256@A+0x800, 88@A+0x1000; single ack_1; word_idx reaches 600.
REQ-034 Interleave: both req same cycle, len 300 each -> grant order 0,1,0,1 with burst lens 256,256,44,44; ack_0 before ack_1.
REQ-035 Backpressure: m_cmd_ready low 10 cycles -> valid and descriptor stable for all 10, beats ignored, then accepted.
REQ-036 Zero length: req_0 len=0 -> ack_0 pulse, m_cmd_valid never asserted.
REQ-037 Reset at beat 2 of 8 -> outputs at reset values immediately, no ack; held req re-runs full 8 words after release.
